// File: rtl/seq_sink.sv
// seq_sink -- captures a burst of words from a pull-style source into an
// internal memory, then holds the result for readback.
//
// A capture starts on 'start'. While filling, the sink pulls one word per
// cycle with 'req'. The capture ends when the memory is full or when the
// source has nothing to offer on a pulled cycle. The stored words stay
// readable through a registered read port.
//
// Handshake: 'req' is a combinational pull request. A word moves on every
// rising edge where req && in_valid are both high. The sink never pulls
// while full, and a cycle with req high and in_valid low ends the capture.
//
// Optional feature: define SEQ_SINK_SUM_EN to build the running checksum
// 'sum' (the sum of the stored words, modulo 2^W). Without it, 'sum' is tied
// to zero.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   one-cycle request to begin (or restart) a capture
//   in_valid   in   source has a word available
//   in_data    in   source word [W]
//   req        out  sink pulls one word this cycle
//   busy       out  capture in progress (FILL)
//   done       out  capture finished, result stable (DONE)
//   full       out  count == SIZE
//   count      out  number of words stored [AW]
//   rd_addr    in   readback address [AW]
//   rd_data    out  readback word, one cycle after rd_addr, 0 if rd_addr >= SIZE
//   sum        out  checksum of the stored words [W]
//   dbg_state  out  current FSM state (0 IDLE, 1 FILL, 2 DONE)
module seq_sink #(
  parameter int W    = 8,
  parameter int SIZE = 256,
  localparam int AW  = $clog2(SIZE + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          req,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW-1:0] count,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic [W-1:0]  sum,
  output logic [1:0]    dbg_state
);

  // Memory index width. A write index is always below SIZE because req
  // is low while full, so the low MW bits of count are enough.
  localparam int MW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [AW-1:0] SIZE_C = AW'(SIZE);
  localparam logic [AW-1:0] LAST_C = AW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] count_q, count_d;
  logic [W-1:0]  rd_data_q;
  logic [W-1:0]  mem_q [SIZE];
  logic          xfer;

  assign full      = (count_q == SIZE_C);
  assign req       = (state_q == FILL) && !full;
  assign xfer      = req && in_valid;
  assign busy      = (state_q == FILL);
  assign done      = (state_q == DONE);
  assign count     = count_q;
  assign rd_data   = rd_data_q;
  assign dbg_state = state_q;

`ifdef SEQ_SINK_SUM_EN
  logic [W-1:0] sum_q, sum_d;
  assign sum = sum_q;
`else
  assign sum = '0;
`endif

  // Next-state logic. Starting a capture (from IDLE or DONE) clears
  // count and sum on the same edge that enters FILL.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
`ifdef SEQ_SINK_SUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          count_d = '0;
`ifdef SEQ_SINK_SUM_EN
          sum_d   = '0;
`endif
        end
      end
      FILL: begin
        // start is ignored here.
        if (full) begin
          state_d = DONE;
        end else if (in_valid) begin
          count_d = count_q + AW'(1);
`ifdef SEQ_SINK_SUM_EN
          sum_d   = sum_q + in_data;
`endif
          if (count_q == LAST_C) state_d = DONE;
        end else begin
          // Pulled but nothing offered: the source is exhausted.
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = FILL;
          count_d = '0;
`ifdef SEQ_SINK_SUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef SEQ_SINK_SUM_EN
  always_ff @(posedge clock) begin
    if (reset) sum_q <= '0;
    else       sum_q <= sum_d;
  end
`endif

  // Memory is never cleared. Reset blocks the write on its own edge so an
  // aborted capture leaves no partial word behind.
  always_ff @(posedge clock) begin
    if (!reset && xfer) mem_q[count_q[MW-1:0]] <= in_data;
  end

  // Registered read. Reading and writing the same address on one edge
  // returns the previous contents.
  always_ff @(posedge clock) begin
    if (reset)                 rd_data_q <= '0;
    else if (rd_addr >= SIZE_C) rd_data_q <= '0;
    else                       rd_data_q <= mem_q[rd_addr[MW-1:0]];
  end

endmodule

// File: tb/tb_seq_sink.sv
module tb_seq_sink;

  localparam int W    = 8;
  localparam int SIZE = 4;
  localparam int AW   = $clog2(SIZE + 1);

  // Signal selectors for checks.
  localparam int S_REQ   = 0;
  localparam int S_BUSY  = 1;
  localparam int S_DONE  = 2;
  localparam int S_FULL  = 3;
  localparam int S_COUNT = 4;
  localparam int S_RD    = 5;
  localparam int S_SUM   = 6;
  localparam int S_STATE = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          req;
  logic          busy;
  logic          done;
  logic          full;
  logic [AW-1:0] count;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  sum;
  logic [1:0]    dbg_state;

  seq_sink #(.W(W), .SIZE(SIZE)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .req       (req),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .sum       (sum),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc_cnt = 0;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } chk_t;

  chk_t chk_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_REQ:   return 32'(req);
      S_BUSY:  return 32'(busy);
      S_DONE:  return 32'(done);
      S_FULL:  return 32'(full);
      S_COUNT: return 32'(count);
      S_RD:    return 32'(rd_data);
      S_SUM:   return 32'(sum);
      default: return 32'(dbg_state);
    endcase
  endfunction

  // Monitor: samples on the falling edge, away from the active edge, and
  // pops every expectation stamped for the current cycle.
  always @(negedge clock) begin
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc_cnt) begin
      chk_t c;
      logic [31:0] a;
      c = chk_q.pop_front();
      a = actual(c.sel);
      checks++;
      if (a !== c.val) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", c.name, a, c.val, cyc_cnt);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_sig(input int sel, input logic [31:0] val, input string name);
    chk_t c;
    c.cyc  = cyc_cnt;
    c.sel  = sel;
    c.val  = val;
    c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_flags(input logic r, input logic b, input logic d, input logic f,
                              input int cnt, input string tag);
    expect_sig(S_REQ,   32'(r),   {tag, "_req"});
    expect_sig(S_BUSY,  32'(b),   {tag, "_busy"});
    expect_sig(S_DONE,  32'(d),   {tag, "_done"});
    expect_sig(S_FULL,  32'(f),   {tag, "_full"});
    expect_sig(S_COUNT, 32'(cnt), {tag, "_count"});
  endtask

  function automatic logic [31:0] exp_sum(input logic [W-1:0] s);
`ifdef SEQ_SINK_SUM_EN
    return 32'(s);
`else
    return 32'(s & 8'h00);
`endif
  endfunction

  // ---------------- directed stimulus ----------------
  logic [W-1:0] fill_vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0;
    tick();
    tick();
    // Reset state
    expect_flags(0, 0, 0, 0, 0, "rst");
    expect_sig(S_RD,    32'h0, "rst_rd");
    expect_sig(S_SUM,   32'h0, "rst_sum");
    expect_sig(S_STATE, 32'd0, "rst_state");
    reset = 1'b0;

    // Full capture of 4 words
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = fill_vec[i];
      expect_flags(1, 1, 0, 0, i, $sformatf("fill%0d", i));
      tick();
    end
    in_valid = 1'b0;
    rd_addr  = 3'd2;
    expect_flags(0, 0, 1, 1, 4, "full4");
    expect_sig(S_SUM,   exp_sum(8'hAA), "full4_sum");
    expect_sig(S_STATE, 32'd2, "full4_state");
    tick();
    expect_sig(S_RD, 32'h33, "rd_addr2");
    rd_addr = 3'd4;
    tick();
    expect_sig(S_RD, 32'h00, "rd_addr_size");
    rd_addr = 3'd3;
    tick();
    expect_sig(S_RD, 32'h44, "rd_addr3");
    rd_addr = 3'd7;
    tick();
    expect_sig(S_RD, 32'h00, "rd_addr7");

    // Restart from DONE, partial capture, start ignored in FILL
    start = 1'b1;
    tick();
    start    = 1'b0;
    expect_flags(1, 1, 0, 0, 0, "restart");
    expect_sig(S_SUM, 32'h0, "restart_sum");
    in_valid = 1'b1;
    in_data  = 8'h05;
    rd_addr  = 3'd0;       // same edge writes m[0]
    tick();
    expect_sig(S_RD, 32'h11, "same_cycle_old");
    expect_sig(S_COUNT, 32'd1, "part1_count");
    in_data = 8'h06;
    start   = 1'b1;        // ignored while filling
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    expect_flags(1, 1, 0, 0, 2, "part2");
    expect_sig(S_RD, 32'h05, "rd_new0");
    tick();
    expect_flags(0, 0, 1, 0, 2, "partdone");
    expect_sig(S_SUM, exp_sum(8'h0B), "partdone_sum");
    rd_addr = 3'd2;
    tick();
    expect_sig(S_RD, 32'h33, "mem_kept2");

    // Reset mid-FILL after one transfer
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    expect_sig(S_COUNT, 32'd1, "pre_abort_count");
    in_data = 8'h88;
    reset   = 1'b1;
    start   = 1'b1;        // reset wins over start and transfer
    tick();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    expect_flags(0, 0, 0, 0, 0, "abort");
    expect_sig(S_STATE, 32'd0, "abort_state");
    expect_sig(S_RD,    32'h0, "abort_rd");
    rd_addr = 3'd0;
    tick();
    expect_sig(S_RD, 32'h77, "abort_word0");
    rd_addr = 3'd1;
    tick();
    expect_sig(S_RD, 32'h06, "abort_no_write");

    // Zero-word capture
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_flags(1, 1, 0, 0, 0, "zero_fill");
    tick();
    expect_flags(0, 0, 1, 0, 0, "zero_done");
    expect_sig(S_SUM, 32'h0, "zero_sum");

    // Reset while in DONE with start asserted
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    expect_sig(S_STATE, 32'd0, "rst_over_start");

    tick();
    tick();
    if (chk_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d checks left unexamined, expected 0", chk_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
